// File: rtl/testharness_pkg.sv
// Shared types and default timing for the power-switch emulation block.
package testharness_pkg;

    typedef enum logic [1:0] {
        STABLE_OFF = 2'b00,
        STABLE_ON  = 2'b01,
        RAMP_UP    = 2'b10,
        RAMP_DOWN  = 2'b11
    } pg_state_e;

    localparam int unsigned DEF_ON_LATENCY  = 15;
    localparam int unsigned DEF_OFF_LATENCY = 15;
    localparam int unsigned DEF_CNT_W       = 8;

    function automatic pg_state_e stable_state(input logic powered);
        return powered ? STABLE_ON : STABLE_OFF;
    endfunction

endpackage

// File: rtl/pg_switch_domain.sv
// One emulated power-gated domain: switch-cell ramp FSM, ack event and
// isolation protocol checker.
//
// state      | meaning
// STABLE_OFF | domain unpowered, ack low, waiting for switch request
// STABLE_ON  | domain powered, ack high, waiting for switch release
// RAMP_UP    | power-up ramp in progress, counter running down
// RAMP_DOWN  | power-down ramp in progress, counter running down
module pg_switch_domain
    import testharness_pkg::*;
#(
    parameter int unsigned ON_LATENCY  = DEF_ON_LATENCY,
    parameter int unsigned OFF_LATENCY = DEF_OFF_LATENCY,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter bit          RESET_ON    = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic switch_i,
    input  logic iso_i,
    output logic switch_ack_o,
    output logic busy_o,
    output logic ack_evt_o,
    output logic iso_err_o
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_LATENCY - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pg_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             switch_q;
    logic             iso_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= stable_state(RESET_ON);
            cnt_q        <= '0;
            switch_ack_o <= RESET_ON;
            busy_o       <= 1'b0;
            done_q       <= 1'b0;
            ack_evt_o    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            ack_evt_o <= done_q;
            case (state_q)
                STABLE_ON: begin
                    if (!switch_i) begin
                        state_q <= RAMP_DOWN;
                        cnt_q   <= OFF_LOAD;
                        busy_o  <= 1'b1;
                    end
                end
                STABLE_OFF: begin
                    if (switch_i) begin
                        state_q <= RAMP_UP;
                        cnt_q   <= ON_LOAD;
                        busy_o  <= 1'b1;
                    end
                end
                // A request that returns to the current ack value wins over
                // completion, even when the counter has already reached zero.
                RAMP_UP: begin
                    if (!switch_i) begin
                        state_q <= STABLE_OFF;
                        cnt_q   <= '0;
                        busy_o  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q      <= STABLE_ON;
                        switch_ack_o <= 1'b1;
                        busy_o       <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RAMP_DOWN: begin
                    if (switch_i) begin
                        state_q <= STABLE_ON;
                        cnt_q   <= '0;
                        busy_o  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q      <= STABLE_OFF;
                        switch_ack_o <= 1'b0;
                        busy_o       <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q      <= stable_state(RESET_ON);
                    cnt_q        <= '0;
                    switch_ack_o <= RESET_ON;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

    // Edge detection uses the previously sampled request/isolation values;
    // the iso check looks at the ack as it stood before this edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            switch_q  <= RESET_ON;
            iso_q     <= 1'b0;
            iso_err_o <= 1'b0;
        end else begin
            switch_q <= switch_i;
            iso_q    <= iso_i;
            if ((switch_q && !switch_i && !iso_i) ||
                (iso_q && !iso_i && !switch_ack_o)) begin
                iso_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pg_switch_emu.sv
// Power-switch emulator: NUM_DOMAINS independent switch-cell models with
// registered acks, ramp busy flags and a sticky isolation-protocol error.
module pg_switch_emu
    import testharness_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 4,
    parameter int unsigned ON_LATENCY  = DEF_ON_LATENCY,
    parameter int unsigned OFF_LATENCY = DEF_OFF_LATENCY,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter bit          RESET_ON    = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_DOMAINS-1:0] switch_i,
    input  logic [NUM_DOMAINS-1:0] iso_i,
    output logic [NUM_DOMAINS-1:0] switch_ack_o,
    output logic [NUM_DOMAINS-1:0] busy_o,
    output logic [NUM_DOMAINS-1:0] ack_evt_o,
    output logic                   iso_err_o,
    output logic [NUM_DOMAINS-1:0] iso_err_dom_o
);

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
        pg_switch_domain #(
            .ON_LATENCY (ON_LATENCY),
            .OFF_LATENCY(OFF_LATENCY),
            .CNT_W      (CNT_W),
            .RESET_ON   (RESET_ON)
        ) u_dom (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .switch_i    (switch_i[g]),
            .iso_i       (iso_i[g]),
            .switch_ack_o(switch_ack_o[g]),
            .busy_o      (busy_o[g]),
            .ack_evt_o   (ack_evt_o[g]),
            .iso_err_o   (iso_err_dom_o[g])
        );
    end

    // Per-domain flags are already registered and sticky, so the summary
    // flag follows them with the same timing.
    assign iso_err_o = |iso_err_dom_o;

endmodule

// File: tb/tb_pg_switch_emu.sv
// Self-checking bench: directed scenarios plus random traffic on two
// differently parameterised instances, compared against a deadline model.
module tb_pg_switch_emu;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [ND-1:0] sw;
    logic [ND-1:0] iso;

    logic [ND-1:0] a_ack, a_busy, a_evt, a_dom;
    logic [ND-1:0] b_ack, b_busy, b_evt, b_dom;
    logic          a_err, b_err;

    int ntest = 0;
    int nfail = 0;
    int ecnt  = 0;

    int lat_on [2] = '{15, 1};
    int lat_off[2] = '{15, 3};
    bit rst_on [2] = '{1'b1, 1'b0};

    bit m_ack [2][ND];
    bit m_ramp[2][ND];
    bit m_evt [2][ND];
    bit m_fin [2][ND];
    bit m_err [2][ND];
    bit m_swp [2][ND];
    bit m_isop[2][ND];
    int m_done[2][ND];

    always #5 clk = ~clk;

    pg_switch_emu #(.NUM_DOMAINS(ND)) dut_a (
        .clk_i(clk), .rst_i(rst), .switch_i(sw), .iso_i(iso),
        .switch_ack_o(a_ack), .busy_o(a_busy), .ack_evt_o(a_evt),
        .iso_err_o(a_err), .iso_err_dom_o(a_dom)
    );

    pg_switch_emu #(
        .NUM_DOMAINS(ND), .ON_LATENCY(1), .OFF_LATENCY(3), .CNT_W(4), .RESET_ON(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .switch_i(sw), .iso_i(iso),
        .switch_ack_o(b_ack), .busy_o(b_busy), .ack_evt_o(b_evt),
        .iso_err_o(b_err), .iso_err_dom_o(b_dom)
    );

    task automatic chk(input string tag, input logic [ND-1:0] obs, input logic [ND-1:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, ecnt, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int d = 0; d < ND; d++) begin
                m_ack[u][d]  = rst_on[u];
                m_ramp[u][d] = 1'b0;
                m_evt[u][d]  = 1'b0;
                m_fin[u][d]  = 1'b0;
                m_err[u][d]  = 1'b0;
                m_swp[u][d]  = rst_on[u];
                m_isop[u][d] = 1'b0;
                m_done[u][d] = 0;
            end
        end
    endtask

    // A ramp started at edge k completes at edge k+latency unless the request
    // goes back to the ack value first; the event follows one edge later.
    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            for (int d = 0; d < ND; d++) begin
                bit e;
                e = m_err[u][d] || (m_swp[u][d] && !sw[d] && !iso[d]) ||
                    (m_isop[u][d] && !iso[d] && !m_ack[u][d]);
                m_evt[u][d] = m_fin[u][d];
                m_fin[u][d] = 1'b0;
                if (!m_ramp[u][d]) begin
                    if (sw[d] != m_ack[u][d]) begin
                        m_ramp[u][d] = 1'b1;
                        m_done[u][d] = ecnt + (sw[d] ? lat_on[u] : lat_off[u]);
                    end
                end else if (sw[d] == m_ack[u][d]) begin
                    m_ramp[u][d] = 1'b0;
                end else if (ecnt == m_done[u][d]) begin
                    m_ack[u][d]  = ~m_ack[u][d];
                    m_ramp[u][d] = 1'b0;
                    m_fin[u][d]  = 1'b1;
                end
                m_swp[u][d]  = sw[d];
                m_isop[u][d] = iso[d];
                m_err[u][d]  = e;
            end
        end
    endtask

    task automatic check_all();
        logic [1:0][ND-1:0] e_ack, e_busy, e_evt, e_dom;
        for (int u = 0; u < 2; u++) begin
            for (int d = 0; d < ND; d++) begin
                e_ack[u][d]  = m_ack[u][d];
                e_busy[u][d] = m_ramp[u][d];
                e_evt[u][d]  = m_evt[u][d];
                e_dom[u][d]  = m_err[u][d];
            end
        end
        chk("a_ack",  a_ack,  e_ack[0]);
        chk("a_busy", a_busy, e_busy[0]);
        chk("a_evt",  a_evt,  e_evt[0]);
        chk("a_dom",  a_dom,  e_dom[0]);
        chk("a_err",  ND'(a_err), ND'(|e_dom[0]));
        chk("b_ack",  b_ack,  e_ack[1]);
        chk("b_busy", b_busy, e_busy[1]);
        chk("b_evt",  b_evt,  e_evt[1]);
        chk("b_dom",  b_dom,  e_dom[1]);
        chk("b_err",  ND'(b_err), ND'(|e_dom[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        ecnt++;
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        rst = 1'b0;
        ecnt = 0;
    endtask

    initial begin
        sw  = '1;
        iso = '1;
        do_reset();

        // Domain 0 power-down at edge 10; domain 1 aborted ramp 5..9;
        // domain 2 switch falls without isolation at edge 31.
        for (int e = 1; e <= 50; e++) begin
            sw[0] = (e < 10) ? 1'b0 + 1'b1 : 1'b0;
            sw[1] = !(e >= 5 && e < 9);
            sw[2] = (e < 31);
            iso[2] = !(e >= 31 && e < 36);
            tick();
            if (e == 9)  chk("abort_busy_low", ND'(a_busy[1]), ND'(0));
            if (e == 10) chk("ramp_busy_start", ND'(a_busy[0]), ND'(1));
            if (e == 24) chk("ack_before_latency", ND'(a_ack[0]), ND'(1));
            if (e == 25) chk("ack_at_latency", ND'(a_ack[0]), ND'(0));
            if (e == 26) chk("evt_after_ack", a_evt, 4'b0001);
            if (e == 31) chk("iso_violation_mask", a_dom, 4'b0100);
        end
        chk("iso_violation_sticky", a_dom, 4'b0100);

        // Power domain 0 back up and reset at ramp cycle 7.
        sw  = '1;
        iso = '1;
        repeat (7) tick();
        chk("midramp_busy", ND'(a_busy[0]), ND'(1));
        do_reset();
        chk("reset_clears_err", ND'(a_err), ND'(0));
        repeat (20) tick();

        // Latency-1 corner on instance B domain 3.
        sw = '0;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            sw = (e == 3 || e == 4) ? 4'b1000 : 4'b0000;
            tick();
            if (e == 3) chk("lat1_ack_pre", ND'(b_ack[3]), ND'(0));
            if (e == 4) chk("lat1_ack_rise", ND'(b_ack[3]), ND'(1));
            if (e == 7) chk("lat1_off_pre", ND'(b_ack[3]), ND'(1));
            if (e == 8) chk("lat1_off_fall", ND'(b_ack[3]), ND'(0));
        end

        // All domains power down together.
        sw = '1;
        do_reset();
        for (int e = 1; e <= 22; e++) begin
            sw = (e < 3) ? 4'b1111 : 4'b0000;
            tick();
            if (e == 17) chk("all_ack_pre", a_ack, 4'b1111);
            if (e == 18) chk("all_ack_fall", a_ack, 4'b0000);
            if (e == 19) chk("all_evt", a_evt, 4'b1111);
            if (e == 20) chk("all_evt_gone", a_evt, 4'b0000);
        end

        // Random traffic.
        for (int r = 0; r < 3; r++) begin
            sw  = (r == 1) ? 4'b0000 : 4'b1111;
            iso = '1;
            do_reset();
            for (int c = 0; c < 400; c++) begin
                for (int d = 0; d < ND; d++) begin
                    if ($urandom_range(0, 11) == 0) sw[d] = ~sw[d];
                    if ($urandom_range(0, 15) == 0) iso[d] = ~iso[d];
                end
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
